// File: rtl/grad_stream_pkg.sv
// Shared constants and state encoding for the gradient-path FIFO stream writer.
package grad_stream_pkg;
  localparam int FIFO_W   = 33;
  localparam int LAST_BIT = 32;
  localparam int LANE_W   = 32;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;
endpackage

// File: rtl/grad_credit_counter.sv
// Free-slot counter for a FIFO writer with no backpressure: push consumes a credit,
// pop returns one; a pop while already full is dropped and flagged.
module grad_credit_counter #(
  parameter int DEPTH = 32,
  parameter int W     = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  output logic [W-1:0] count,
  output logic         err
);
  localparam logic [W-1:0] FULL = W'(DEPTH);

  logic pop_ok;
  assign pop_ok = pop && (count != FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= FULL;
      err   <= 1'b0;
    end else begin
      // push is only issued with count > 0, so this cannot underflow
      count <= count - W'(push) + W'(pop_ok);
      if (pop && !pop_ok) err <= 1'b1;
    end
  end
endmodule

// File: rtl/grad_stream_serializer.sv
// Splits wide AXI-Stream beats into 32-bit lanes and writes them as 33-bit words
// (bit 32 = message end) into a FIFO whose occupancy is tracked by credits.
module grad_stream_serializer
  import grad_stream_pkg::*;
#(
  parameter int WIDE_BITS  = 512,
  parameter int LANES      = WIDE_BITS / 32,
  parameter int FIFO_DEPTH = 32,
  parameter int CRED_BITS  = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDE_BITS-1:0] s_axis_tdata,
  input  logic [LANES-1:0]     s_axis_tkeep,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [FIFO_W-1:0]    m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 fifo_pop,
  output logic [CRED_BITS-1:0] credits,
  output logic                 busy,
  output logic                 err_empty_beat,
  output logic                 err_credit
);
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  state_e                        state;
  logic [IDX_W-1:0]              idx;
  logic [IDX_W-1:0]              last_idx;
  logic [LANES-1:0][LANE_W-1:0]  hold_data;
  logic                          hold_last;
  logic                          push;
  logic                          at_last;
  logic                          accept;

  // tkeep is contiguous from lane 0, so the highest set bit marks the final lane
  function automatic logic [IDX_W-1:0] top_lane(input logic [LANES-1:0] keep);
    top_lane = '0;
    for (int i = 0; i < LANES; i++)
      if (keep[i]) top_lane = IDX_W'(i);
  endfunction

  assign push          = (state == SEND) && (credits != '0);
  assign at_last       = (idx == last_idx);
  assign s_axis_tready = (state == IDLE) || (push && at_last);
  assign accept        = s_axis_tvalid && s_axis_tready;

  grad_credit_counter #(
    .DEPTH (FIFO_DEPTH),
    .W     (CRED_BITS)
  ) u_credit (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (fifo_pop),
    .count (credits),
    .err   (err_credit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= '0;
      m_axis_tvalid  <= 1'b0;
      m_axis_tdata   <= '0;
      busy           <= 1'b0;
      err_empty_beat <= 1'b0;
    end else begin
      m_axis_tvalid <= push;
      if (push) begin
        m_axis_tdata[LANE_W-1:0] <= hold_data[idx];
        m_axis_tdata[LAST_BIT]   <= hold_last && at_last;
        idx                      <= idx + IDX_W'(1);
      end
      if (accept) begin
        if (s_axis_tkeep == '0) begin
          // empty beat is dropped along with its tlast
          err_empty_beat <= 1'b1;
          state          <= IDLE;
          busy           <= 1'b0;
        end else begin
          hold_data <= s_axis_tdata;
          hold_last <= s_axis_tlast;
          last_idx  <= top_lane(s_axis_tkeep);
          idx       <= '0;
          state     <= SEND;
          busy      <= 1'b1;
        end
      end else if (push && at_last) begin
        state <= IDLE;
        busy  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_grad_stream_serializer.sv
// Scoreboard bench: two serializers (FIFO depth 32 and 4), 128-bit beats.
module tb_grad_stream_serializer;
  localparam int WB = 128;
  localparam int LN = 4;
  localparam int CB = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          a_rst, a_valid, a_last, a_ready, a_mvalid, a_pop, a_busy, a_eeb, a_ec;
  logic [WB-1:0] a_data;
  logic [LN-1:0] a_keep;
  logic [32:0]   a_mdata;
  logic [CB-1:0] a_cred;

  logic          b_rst, b_valid, b_last, b_ready, b_mvalid, b_pop, b_busy, b_eeb, b_ec;
  logic [WB-1:0] b_data;
  logic [LN-1:0] b_keep;
  logic [32:0]   b_mdata;
  logic [CB-1:0] b_cred;

  grad_stream_serializer #(.WIDE_BITS(WB), .FIFO_DEPTH(32), .CRED_BITS(CB)) dut_a (
    .clk(clk), .rst(a_rst), .s_axis_tdata(a_data), .s_axis_tkeep(a_keep),
    .s_axis_tlast(a_last), .s_axis_tvalid(a_valid), .s_axis_tready(a_ready),
    .m_axis_tdata(a_mdata), .m_axis_tvalid(a_mvalid), .fifo_pop(a_pop),
    .credits(a_cred), .busy(a_busy), .err_empty_beat(a_eeb), .err_credit(a_ec));

  grad_stream_serializer #(.WIDE_BITS(WB), .FIFO_DEPTH(4), .CRED_BITS(CB)) dut_b (
    .clk(clk), .rst(b_rst), .s_axis_tdata(b_data), .s_axis_tkeep(b_keep),
    .s_axis_tlast(b_last), .s_axis_tvalid(b_valid), .s_axis_tready(b_ready),
    .m_axis_tdata(b_mdata), .m_axis_tvalid(b_mvalid), .fifo_pop(b_pop),
    .credits(b_cred), .busy(b_busy), .err_empty_beat(b_eeb), .err_credit(b_ec));

  int passed = 0;
  int total  = 0;
  logic [32:0] qa[$];
  logic [32:0] qb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  // monitors: every strobe must match the next expected word
  always @(negedge clk) begin
    if (a_mvalid === 1'b1) begin
      if (qa.size() == 0) begin
        total++;
        $display("FAIL a_unexpected_word: got %0h expected none", a_mdata);
      end else chk("a_word", 64'(a_mdata), 64'(qa.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (b_mvalid === 1'b1) begin
      if (qb.size() == 0) begin
        total++;
        $display("FAIL b_unexpected_word: got %0h expected none", b_mdata);
      end else chk("b_word", 64'(b_mdata), 64'(qb.pop_front()));
    end
  end

  initial begin
    bit accepted;
    a_rst = 1'b1; a_valid = 1'b0; a_last = 1'b0; a_pop = 1'b0; a_data = '0; a_keep = '0;
    b_rst = 1'b1; b_valid = 1'b0; b_last = 1'b0; b_pop = 1'b0; b_data = '0; b_keep = '0;
    repeat (2) step();
    a_rst = 1'b0;
    b_rst = 1'b0;

    // reset state
    samp();
    chk("a_rst_mvalid", 64'(a_mvalid), 64'(0));
    chk("a_rst_mdata",  64'(a_mdata),  64'(0));
    chk("a_rst_cred",   64'(a_cred),   64'(32));
    chk("a_rst_busy",   64'(a_busy),   64'(0));
    chk("a_rst_errs",   64'({a_eeb, a_ec}), 64'(0));
    chk("a_rst_ready",  64'(a_ready),  64'(1));
    chk("b_rst_cred",   64'(b_cred),   64'(4));

    // full beat, tlast on lane 3
    step();
    a_data = {32'h44, 32'h33, 32'h22, 32'h11}; a_keep = 4'b1111; a_last = 1'b1; a_valid = 1'b1;
    qa.push_back(33'h0_0000_0011); qa.push_back(33'h0_0000_0022);
    qa.push_back(33'h0_0000_0033); qa.push_back(33'h1_0000_0044);
    samp(); chk("full_ready_idle", 64'(a_ready), 64'(1));
    step(); a_valid = 1'b0;
    samp(); chk("full_lat_c0", 64'(a_mvalid), 64'(0)); chk("full_ready_c0", 64'(a_ready), 64'(0));
    chk("full_busy", 64'(a_busy), 64'(1));
    step(); samp(); chk("full_ready_c1", 64'(a_ready), 64'(0)); chk("full_strobe_c1", 64'(a_mvalid), 64'(1));
    step(); samp(); chk("full_ready_c2", 64'(a_ready), 64'(0));
    step(); samp(); chk("full_ready_c3", 64'(a_ready), 64'(1));
    step(); samp(); chk("full_strobe_c4", 64'(a_mvalid), 64'(1)); chk("full_idle", 64'(a_busy), 64'(0));
    step(); samp(); chk("full_cred", 64'(a_cred), 64'(28));

    // partial beat, then back-to-back single-lane beat
    step();
    a_data = {32'hDEAD, 32'hBEEF, 32'hA2, 32'hA1}; a_keep = 4'b0011; a_last = 1'b1; a_valid = 1'b1;
    qa.push_back(33'h0_0000_00A1); qa.push_back(33'h1_0000_00A2); qa.push_back(33'h0_0000_00B1);
    samp(); chk("part_ready_idle", 64'(a_ready), 64'(1));
    step(); a_valid = 1'b0;
    samp(); chk("part_ready_c0", 64'(a_ready), 64'(0));
    step(); a_data = {32'h0, 32'h0, 32'h0, 32'hB1}; a_keep = 4'b0001; a_last = 1'b0; a_valid = 1'b1;
    samp(); chk("part_ready_last", 64'(a_ready), 64'(1)); chk("part_strobe1", 64'(a_mvalid), 64'(1));
    step(); a_valid = 1'b0;
    samp(); chk("part_strobe2", 64'(a_mvalid), 64'(1)); chk("part_busy2", 64'(a_busy), 64'(1));
    step(); samp(); chk("b2b_no_bubble", 64'(a_mvalid), 64'(1)); chk("b2b_idle", 64'(a_busy), 64'(0));
    step(); samp(); chk("b2b_done", 64'(a_mvalid), 64'(0)); chk("part_cred", 64'(a_cred), 64'(25));

    // empty beat
    step();
    a_data = {4{32'hFFFF_FFFF}}; a_keep = 4'b0000; a_last = 1'b1; a_valid = 1'b1;
    samp(); chk("empty_ready", 64'(a_ready), 64'(1));
    step(); a_valid = 1'b0;
    samp(); chk("empty_err", 64'(a_eeb), 64'(1)); chk("empty_busy", 64'(a_busy), 64'(0));
    step(); samp(); chk("empty_nostrobe", 64'(a_mvalid), 64'(0));

    // return all credits, then one extra pop
    step(); a_pop = 1'b1;
    repeat (7) @(posedge clk);
    #1 a_pop = 1'b0;
    samp(); chk("pop_refill", 64'(a_cred), 64'(32)); chk("pop_no_err", 64'(a_ec), 64'(0));
    step(); a_pop = 1'b1;
    step(); a_pop = 1'b0;
    samp(); chk("over_pop_cred", 64'(a_cred), 64'(32)); chk("over_pop_err", 64'(a_ec), 64'(1));
    chk("err_sticky", 64'(a_eeb), 64'(1));

    // depth-4 instance: credit stall, pop release, simultaneous push/pop, reset mid-SEND
    step();
    b_data = {32'h4, 32'h3, 32'h2, 32'h1}; b_keep = 4'b1111; b_last = 1'b0; b_valid = 1'b1;
    qb.push_back(33'h0_0000_0001); qb.push_back(33'h0_0000_0002);
    qb.push_back(33'h0_0000_0003); qb.push_back(33'h0_0000_0004);
    qb.push_back(33'h0_0000_0055); qb.push_back(33'h0_0000_0066);
    samp(); chk("b_ready_idle", 64'(b_ready), 64'(1));
    step(); b_data = {32'h88, 32'h77, 32'h66, 32'h55}; b_last = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 10; i++) begin
      samp();
      if (b_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    chk("b_second_accept", 64'(accepted), 64'(1));
    step(); b_valid = 1'b0;
    samp(); chk("stall_cred", 64'(b_cred), 64'(0)); chk("stall_busy", 64'(b_busy), 64'(1));
    step(); samp(); chk("stall_c1", 64'(b_mvalid), 64'(0));
    step(); samp(); chk("stall_c2", 64'(b_mvalid), 64'(0)); chk("stall_cred2", 64'(b_cred), 64'(0));
    step(); b_pop = 1'b1;
    step(); b_pop = 1'b0;
    samp(); chk("pop_cred1", 64'(b_cred), 64'(1)); chk("pop_not_yet", 64'(b_mvalid), 64'(0));
    b_pop = 1'b1;
    step(); b_pop = 1'b0;
    samp(); chk("pop_one_word", 64'(b_mvalid), 64'(1)); chk("pushpop_cred", 64'(b_cred), 64'(1));
    step(); samp(); chk("pushpop_next", 64'(b_mvalid), 64'(1)); chk("cred_zero", 64'(b_cred), 64'(0));
    step(); samp(); chk("restall", 64'(b_mvalid), 64'(0)); chk("restall_busy", 64'(b_busy), 64'(1));
    step(); b_rst = 1'b1;
    step(); b_rst = 1'b0;
    samp();
    chk("rst_mid_mvalid", 64'(b_mvalid), 64'(0));
    chk("rst_mid_mdata",  64'(b_mdata),  64'(0));
    chk("rst_mid_cred",   64'(b_cred),   64'(4));
    chk("rst_mid_busy",   64'(b_busy),   64'(0));
    chk("rst_mid_ready",  64'(b_ready),  64'(1));
    repeat (4) step();
    samp(); chk("rst_quiet", 64'(b_mvalid), 64'(0)); chk("rst_quiet_busy", 64'(b_busy), 64'(0));

    for (int i = 0; i < 50 && (qa.size() != 0 || qb.size() != 0); i++) samp();
    chk("qa_drained", 64'(qa.size()), 64'(0));
    chk("qb_drained", 64'(qb.size()), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
